// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter bank.
//   perf_state_e : bank control state (IDLE, RUN, FROZEN)
//   EV_*         : conventional channel assignments for the event vector
//   sel_width()  : width of a channel-select field for n channels (min 1)
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } perf_state_e;

  localparam int unsigned EV_INST  = 0;
  localparam int unsigned EV_ICREQ = 1;
  localparam int unsigned EV_ICHIT = 2;
  localparam int unsigned EV_DCREQ = 3;
  localparam int unsigned EV_DCHIT = 4;
  localparam int unsigned EV_CYCLE = 5;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_counter.sv
// Single event counter with synchronous clear and sticky overflow flag.
// Optional build macro PERF_SNAPSHOT_EN exposes the next-state count so the
// bank can capture it into a shadow register in the same cycle.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous clear of count and overflow (wins over inc)
//   inc          count one event this cycle
//   cnt          current count
//   ovf          sticky overflow flag
//   cnt_nxt      (PERF_SNAPSHOT_EN only) count after this cycle's update
module perf_counter
  import perf_pkg::*;
#(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned SAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
`ifdef PERF_SNAPSHOT_EN
  output logic [CNT_W-1:0] cnt_nxt,
`endif
  output logic             ovf
);

  localparam logic [CNT_W-1:0] One = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc) begin
      if (&cnt_q) begin
        // Event beyond all-ones: flag it, then either hold or wrap.
        ovf_d = 1'b1;
        cnt_d = (SAT != 0) ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + One;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;
`ifdef PERF_SNAPSHOT_EN
  assign cnt_nxt = cnt_d;
`endif

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_EV event counters with IDLE/RUN/FROZEN control and a
// registered single-channel readout.
// Build macro PERF_SNAPSHOT_EN adds a 'snap' input and per-channel shadow
// registers; readout then comes from the shadows instead of live counters.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           counting enable (IDLE->RUN, RUN->IDLE when low)
//   ev           per-channel event strobes
//   hlt          halt strobe, RUN->FROZEN
//   clr          synchronous clear of counters, flags, shadows and state
//   snap         (PERF_SNAPSHOT_EN only) capture all counters into shadows
//   rd_sel       readout channel select; out-of-range reads as zero
//   rd_data      registered count of the selected channel
//   ovf          sticky per-channel overflow flags
//   frozen       registered FROZEN state indicator
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int unsigned NUM_EV = 6,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned SAT    = 1,
  localparam int unsigned SEL_W = sel_width(NUM_EV)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NUM_EV-1:0] ev,
  input  logic              hlt,
  input  logic              clr,
`ifdef PERF_SNAPSHOT_EN
  input  logic              snap,
`endif
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_EV-1:0] ovf,
  output logic              frozen
);

  perf_state_e       state;
  logic [NUM_EV-1:0] inc;
  logic [CNT_W-1:0]  cnt [NUM_EV];
  logic [CNT_W-1:0]  rd_src [NUM_EV];
  logic [CNT_W-1:0]  sel_val;

  // Single-process FSM; frozen is registered alongside the state it decodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      frozen <= 1'b0;
    end else if (clr) begin
      state  <= IDLE;
      frozen <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) state <= RUN;
        end
        RUN: begin
          if (hlt) begin
            state  <= FROZEN;
            frozen <= 1'b1;
          end else if (!en) begin
            state <= IDLE;
          end
        end
        FROZEN: ;
        default: begin
          state  <= IDLE;
          frozen <= 1'b0;
        end
      endcase
    end
  end

  // Events in the cycle that leaves RUN (halt or disable) are still counted.
  assign inc = (state == RUN && !clr) ? ev : '0;

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_W-1:0] cnt_nxt [NUM_EV];
  logic [CNT_W-1:0] shadow  [NUM_EV];
`endif

  for (genvar i = 0; i < NUM_EV; i++) begin : g_cnt
    perf_counter #(
      .CNT_W (CNT_W),
      .SAT   (SAT)
    ) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .inc     (inc[i]),
      .cnt     (cnt[i]),
`ifdef PERF_SNAPSHOT_EN
      .cnt_nxt (cnt_nxt[i]),
`endif
      .ovf     (ovf[i])
    );
  end

`ifdef PERF_SNAPSHOT_EN
  // Shadows take the post-update value so a same-cycle event is included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_EV; i++) shadow[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_EV; i++) shadow[i] <= '0;
    end else if (snap) begin
      for (int i = 0; i < NUM_EV; i++) shadow[i] <= cnt_nxt[i];
    end
  end

  assign rd_src = shadow;
`else
  assign rd_src = cnt;
`endif

  always_comb begin
    sel_val = '0;
    if (32'(rd_sel) < NUM_EV) sel_val = rd_src[rd_sel];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (clr) begin
      rd_data <= '0;
    end else begin
      rd_data <= sel_val;
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed self-checking bench for perf_counter_bank. Three instances share
// the stimulus: the default 32-bit saturating bank and two 8-bit banks
// (saturating and wrapping) used for overflow boundaries.
module tb_perf_counter_bank;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [5:0]  ev;
  logic        hlt;
  logic        clr;
  logic [2:0]  rd_sel;
  logic [31:0] rd_data;
  logic [5:0]  ovf;
  logic        frozen;
  logic [7:0]  rd_data_s;
  logic [5:0]  ovf_s;
  logic        frozen_s;
  logic [7:0]  rd_data_w;
  logic [5:0]  ovf_w;
  logic        frozen_w;
`ifdef PERF_SNAPSHOT_EN
  logic        snap;
`endif

  int checks;
  int failures;

  perf_counter_bank #(.NUM_EV(6), .CNT_W(32), .SAT(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .ev      (ev),
    .hlt     (hlt),
    .clr     (clr),
`ifdef PERF_SNAPSHOT_EN
    .snap    (snap),
`endif
    .rd_sel  (rd_sel),
    .rd_data (rd_data),
    .ovf     (ovf),
    .frozen  (frozen)
  );

  perf_counter_bank #(.NUM_EV(6), .CNT_W(8), .SAT(1)) dut_sat (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .ev      (ev),
    .hlt     (hlt),
    .clr     (clr),
`ifdef PERF_SNAPSHOT_EN
    .snap    (snap),
`endif
    .rd_sel  (rd_sel),
    .rd_data (rd_data_s),
    .ovf     (ovf_s),
    .frozen  (frozen_s)
  );

  perf_counter_bank #(.NUM_EV(6), .CNT_W(8), .SAT(0)) dut_wrap (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .ev      (ev),
    .hlt     (hlt),
    .clr     (clr),
`ifdef PERF_SNAPSHOT_EN
    .snap    (snap),
`endif
    .rd_sel  (rd_sel),
    .rd_data (rd_data_w),
    .ovf     (ovf_w),
    .frozen  (frozen_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    en = 1'b0; ev = '0; hlt = 1'b0; clr = 1'b0; rd_sel = 3'd0;
`ifdef PERF_SNAPSHOT_EN
    snap = 1'b1;  // continuous capture keeps shadow readout equal to live
`endif
    tick(2);
    checks++;
    if (rd_data !== 32'd0) begin
      failures++; $display("FAIL reset_rd_data got=%0d want=0", rd_data);
    end
    checks++;
    if (ovf !== 6'd0) begin
      failures++; $display("FAIL reset_ovf got=%b want=000000", ovf);
    end
    checks++;
    if (frozen !== 1'b0) begin
      failures++; $display("FAIL reset_frozen got=%b want=0", frozen);
    end
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_count;
    en = 1'b1;
    tick(1);                      // IDLE -> RUN
    ev = 6'b100000; rd_sel = 3'd5;
    tick(10);                     // ten counted cycles
    ev = '0;
    tick(1);                      // readout register catches up
    checks++;
    if (rd_data !== 32'd10) begin
      failures++; $display("FAIL count_ch5 got=%0d want=10", rd_data);
    end
    checks++;
    if (ovf !== 6'd0) begin
      failures++; $display("FAIL count_ovf got=%b want=000000", ovf);
    end
    rd_sel = 3'd0;
    tick(1);
    checks++;
    if (rd_data !== 32'd0) begin
      failures++; $display("FAIL count_ch0_idle got=%0d want=0", rd_data);
    end
    rd_sel = 3'd6;
    tick(1);
    checks++;
    if (rd_data !== 32'd0) begin
      failures++; $display("FAIL rd_sel_out_of_range got=%0d want=0", rd_data);
    end
    // Drop enable: RUN -> IDLE, further events must not count.
    en = 1'b0;
    tick(1);
    ev = 6'b111111; rd_sel = 3'd5;
    tick(4);
    ev = '0;
    tick(1);
    checks++;
    if (rd_data !== 32'd10) begin
      failures++; $display("FAIL idle_hold_ch5 got=%0d want=10", rd_data);
    end
  endtask

  task automatic test_clear;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    checks++;
    if (rd_data !== 32'd0) begin
      failures++; $display("FAIL clear_ch5 got=%0d want=0", rd_data);
    end
    tick(1);
    checks++;
    if (rd_data !== 32'd0) begin
      failures++; $display("FAIL clear_ch5_live got=%0d want=0", rd_data);
    end
  endtask

  task automatic test_overflow;
    en = 1'b1;
    tick(1);
    ev = 6'b000001; rd_sel = 3'd0;
    tick(300);
    ev = '0; en = 1'b0;
    tick(2);
    checks++;
    if (rd_data_s !== 8'd255) begin
      failures++; $display("FAIL sat_value got=%0d want=255", rd_data_s);
    end
    checks++;
    if (ovf_s !== 6'b000001) begin
      failures++; $display("FAIL sat_ovf got=%b want=000001", ovf_s);
    end
    checks++;
    if (rd_data_w !== 8'd44) begin
      failures++; $display("FAIL wrap_value got=%0d want=44", rd_data_w);
    end
    checks++;
    if (ovf_w !== 6'b000001) begin
      failures++; $display("FAIL wrap_ovf got=%b want=000001", ovf_w);
    end
    checks++;
    if (rd_data !== 32'd300) begin
      failures++; $display("FAIL wide_value got=%0d want=300", rd_data);
    end
    checks++;
    if (ovf !== 6'd0) begin
      failures++; $display("FAIL wide_ovf got=%b want=000000", ovf);
    end
    // Sticky: flag remains after counting stops.
    tick(3);
    checks++;
    if (ovf_w !== 6'b000001) begin
      failures++; $display("FAIL wrap_ovf_sticky got=%b want=000001", ovf_w);
    end
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    checks++;
    if (ovf_s !== 6'd0) begin
      failures++; $display("FAIL sat_ovf_clear got=%b want=000000", ovf_s);
    end
  endtask

  task automatic test_halt;
    en = 1'b1;
    tick(1);
    ev = 6'b111111;
    tick(2);
    hlt = 1'b1;                   // events in the halt cycle still count
    tick(1);
    hlt = 1'b0;
    checks++;
    if (frozen !== 1'b1) begin
      failures++; $display("FAIL halt_frozen got=%b want=1", frozen);
    end
    // Keep events and enable active; nothing may change while frozen.
    tick(5);
    for (int c = 0; c < 6; c++) begin
      rd_sel = 3'(c);
      tick(1);
      checks++;
      if (rd_data !== 32'd3) begin
        failures++; $display("FAIL halt_count ch=%0d got=%0d want=3", c, rd_data);
      end
    end
    hlt = 1'b1;
    en = 1'b0;
    tick(2);
    hlt = 1'b0;
    checks++;
    if (frozen !== 1'b1) begin
      failures++; $display("FAIL frozen_stays got=%b want=1", frozen);
    end
    checks++;
    if (ovf !== 6'd0) begin
      failures++; $display("FAIL halt_ovf got=%b want=000000", ovf);
    end
  endtask

  task automatic test_frozen_clear;
    en = 1'b1; ev = 6'b111111; clr = 1'b1; rd_sel = 3'd2;
    tick(1);
    clr = 1'b0; en = 1'b0;
    checks++;
    if (frozen !== 1'b0) begin
      failures++; $display("FAIL fclr_frozen got=%b want=0", frozen);
    end
    checks++;
    if (ovf !== 6'd0) begin
      failures++; $display("FAIL fclr_ovf got=%b want=000000", ovf);
    end
    checks++;
    if (rd_data !== 32'd0) begin
      failures++; $display("FAIL fclr_rd_data got=%0d want=0", rd_data);
    end
    // Back in IDLE with en low: events keep being ignored.
    tick(4);
    ev = '0;
    tick(1);
    checks++;
    if (rd_data !== 32'd0) begin
      failures++; $display("FAIL fclr_idle_ch2 got=%0d want=0", rd_data);
    end
  endtask

  task automatic test_async_reset;
    en = 1'b1;
    tick(1);
    ev = 6'b111111; rd_sel = 3'd3;
    tick(7);
    ev = '0;
    tick(1);
    checks++;
    if (rd_data !== 32'd7) begin
      failures++; $display("FAIL pre_reset_ch3 got=%0d want=7", rd_data);
    end
    ev = 6'b111111;               // still RUN with events active
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rd_data !== 32'd0) begin
      failures++; $display("FAIL async_rd_data got=%0d want=0", rd_data);
    end
    checks++;
    if (frozen !== 1'b0) begin
      failures++; $display("FAIL async_frozen got=%b want=0", frozen);
    end
    tick(2);                      // edges while held in reset sample nothing
    ev = '0; en = 1'b0;
    rst_n = 1'b1;
    tick(2);
    checks++;
    if (rd_data !== 32'd0) begin
      failures++; $display("FAIL post_reset_ch3 got=%0d want=0", rd_data);
    end
  endtask

`ifdef PERF_SNAPSHOT_EN
  task automatic test_snapshot;
    snap = 1'b0;
    clr = 1'b1;
    tick(1);
    clr = 1'b0; en = 1'b1;
    tick(1);
    ev = 6'b000010; rd_sel = 3'd1;
    tick(4);                      // live ch1 = 4
    snap = 1'b1;                  // capture includes this cycle's event
    tick(1);
    snap = 1'b0;
    tick(4);                      // live ch1 = 9
    ev = '0;
    tick(1);
    checks++;
    if (rd_data !== 32'd5) begin
      failures++; $display("FAIL snap_shadow got=%0d want=5", rd_data);
    end
    snap = 1'b1;
    tick(1);
    snap = 1'b0;
    tick(1);
    checks++;
    if (rd_data !== 32'd9) begin
      failures++; $display("FAIL snap_resample got=%0d want=9", rd_data);
    end
    en = 1'b0;
    snap = 1'b1;
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_count();
    test_clear();
    test_overflow();
    test_halt();
    test_frozen_clear();
    test_async_reset();
`ifdef PERF_SNAPSHOT_EN
    test_snapshot();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
